mp_add_seq: RTL and testbench

Multi-precision add/subtract sequencer. It computes a WORDS×N-bit sum or difference by running a single N-bit ripple-carry slice WORDS times, least-significant word first, and chains the carry through a register between passes. It sits between a register-file/bus client and the shared adder datapath, so wide arithmetic costs one N-bit adder instead of a WORDS×N-bit one. It exposes a start/busy/done handshake.

---
 rtl/mp_add_pkg.sv | 9 +
 rtl/rca_slice.sv | 20 ++
 rtl/mp_add_seq.sv | 69 ++++++
 tb/tb_mp_add_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types, defaults and helpers for the multi-precision add sequencer
package mp_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t;
  localparam int N_DEF = 8;
  localparam int WORDS_DEF = 4;
  function automatic int idx_w(input int words);
    return words > 1 ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/rca_slice.sv
// rca_slice: structural N-bit ripple-carry adder exposing the MSB carry-in for overflow
module rca_slice #(
  parameter int N = 8
) (
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout     = c[N];
  assign c_msb_in = c[N-1];
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: WORDS-pass add/subtract sequencer reusing one N-bit ripple-carry slice
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               carry_out,
  output logic               overflow
);
  localparam int IW = idx_w(WORDS);
  mp_state_t state, state_nx;
  logic [IW-1:0] idx;
  logic cy, accept, last, s_cout, s_cmsb;
  logic [N*WORDS-1:0] a_r, b_r;
  logic [N-1:0] s_sum;
  rca_slice #(.N(N)) u_slice (
    .cin     (cy),
    .a       (a_r[idx*N +: N]),
    .b       (b_r[idx*N +: N]),
    .sum     (s_sum),
    .cout    (s_cout),
    .c_msb_in(s_cmsb)
  );
  always_comb begin
    accept   = start && state != RUN;
    last     = idx == IW'(WORDS - 1);
    state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    busy     = state == RUN;
    done     = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cy        <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= a;
        b_r <= sub ? ~b : b;
        cy  <= sub;
        idx <= '0;
      end else if (state == RUN) begin
        sum[idx*N +: N] <= s_sum;
        cy              <= s_cout;
        idx             <= last ? idx : idx + IW'(1);
        if (last) begin
          carry_out <= s_cout;
          overflow  <= s_cmsb ^ s_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for mp_add_seq with directed vectors (N=8, WORDS=4)
module tb_mp_add_seq;
  logic clk = 0, rst = 1, start = 0, sub = 0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, carry_out, overflow;
  logic [31:0] sum;
  int checks = 0, errors = 0, cyc = 0, busy_n = 0;
  typedef struct {
    logic [31:0] s;
    logic co;
    logic ov;
    int t0;
  } exp_t;
  exp_t q[$];

  mp_add_seq #(.N(8), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) busy_n = 0;
    else begin
      if (busy) busy_n++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (sum %h)", sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("carry_out", 32'(carry_out), 32'(e.co));
          chk("overflow", 32'(overflow), 32'(e.ov));
          chk("latency", 32'(cyc - e.t0), 32'd4);
          chk("busy_cycles", 32'(busy_n), 32'd4);
          busy_n = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic ss,
                       input logic [31:0] es, input logic eco, input logic eov);
    a = aa; b = bb; sub = ss; start = 1;
    @(posedge clk); #1;
    q.push_back('{s: es, co: eco, ov: eov, t0: cyc});
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending ops expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_sum", sum, 32'h0);
    chk("rst_flags", {28'h0, busy, done, carry_out, overflow}, 32'h0);
    @(negedge clk); rst = 0;
    issue(32'h000000FF, 32'h00000001, 0, 32'h00000100, 0, 0); wait_idle();
    issue(32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0); wait_idle();
    issue(32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1); wait_idle();
    issue(32'h00000005, 32'h00000007, 1, 32'hFFFFFFFE, 0, 0); wait_idle();
    // starts during RUN must be ignored; the one in the DONE cycle is accepted
    issue(32'h12345678, 32'h11111111, 0, 32'h23456789, 0, 0);
    start = 1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom; sub = k[0];
      @(posedge clk); #1;
    end
    a = 32'h80000000; b = 32'h00000001; sub = 1;
    @(posedge clk); #1;
    q.push_back('{s: 32'h7FFFFFFF, co: 1'b1, ov: 1'b1, t0: cyc});
    start = 0;
    wait_idle();
    a = 32'h0F0F0F0F; b = 32'h01010101; sub = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); @(posedge clk); #2;
    chk("busy_mid_run", 32'(busy), 32'd1);
    rst = 1; #1;
    chk("abort_sum", sum, 32'h0);
    chk("abort_flags", {28'h0, busy, done, carry_out, overflow}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", 32'(done), 32'd0);
    issue(32'h0000FFFF, 32'h00000001, 0, 32'h00010000, 0, 0); wait_idle();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end
endmodule
